// File: rtl/btn_conditioner_pkg.sv
// Shared defaults and width helper for the button conditioner.
package btn_conditioner_pkg;

  localparam int unsigned DEF_N_BTN       = 5;
  localparam int unsigned DEF_DB_CYCLES   = 100000;
  localparam int unsigned DEF_HOLD_CYCLES = 50000000;
  localparam int unsigned DEF_RPT_CYCLES  = 10000000;

  // Bits needed to hold any value 0..max_val (clog2(max_val+1), at least 1).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 1) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_conditioner_channel.sv
// One button channel: 2-flop synchronizer, debounce, long-press and auto-repeat.
module btn_channel
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned RPT_CYCLES  = DEF_RPT_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int unsigned DB_W   = cnt_width(DB_CYCLES - 1);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES + RPT_CYCLES);
  localparam int unsigned RPT_W  = cnt_width(RPT_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [RPT_W-1:0]  RPT_LAST = RPT_W'((RPT_CYCLES == 0) ? 0 : RPT_CYCLES - 1);
  localparam bit                RPT_EN   = (RPT_CYCLES != 0);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [RPT_W-1:0]  rpt_q, rpt_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;

  // Next-state: synchronize, debounce the synchronized level, then track hold time.
  always_comb begin
    sync1_d   = i_btn;
    sync2_d   = sync1_q;
    db_cnt_d  = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = '0;
    rpt_d     = '0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    // A mismatch must persist DB_CYCLES consecutive cycles; any agreement restarts it.
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d   = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // Hold counter reads 1 in the press cycle, saturates at HOLD_CYCLES;
    // repeats then run off their own wrapping sub-counter. Release clears all
    // in the same cycle o_release rises, so a repeat can never coincide with it.
    if (level_d) begin
      if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + 1'b1;
        long_d = (hold_d == HOLD_MAX);
      end else begin
        hold_d = hold_q;
        if (RPT_EN) begin
          if (rpt_q == RPT_LAST) begin
            rpt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end
      end
    end
  end

  // State and output registers, all cleared by asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= '0;
      rpt_q     <= '0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      rpt_q     <= rpt_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: one independent btn_channel per input bit.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int unsigned N_BTN       = DEF_N_BTN,
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned RPT_CYCLES  = DEF_RPT_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_long,
  output logic [N_BTN-1:0] o_repeat
);

  // One fully independent conditioner per button bit.
  for (genvar k = 0; k < N_BTN; k++) begin : g_ch
    btn_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES),
      .RPT_CYCLES (RPT_CYCLES)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_btn    (i_btn[k]),
      .o_level  (o_level[k]),
      .o_press  (o_press[k]),
      .o_release(o_release[k]),
      .o_long   (o_long[k]),
      .o_repeat (o_repeat[k])
    );
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter N_BTN, 5, number of independent button channels (1..32).
REQ-002 Parameter DB_CYCLES, 100000, consecutive stable cycles required to accept a level change (>=2).
REQ-003 Parameter HOLD_CYCLES, 50000000, cycles of accepted press before long-press pulse (>DB_CYCLES).
REQ-004 Parameter RPT_CYCLES, 10000000, auto-repeat period after long-press; 0 disables repeat.
REQ-005 i_clk  input  1  single clock; all logic on rising edge.
REQ-006 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 i_btn  input  N_BTN  raw asynchronous button levels, bit k = channel k, active-high.
REQ-008 o_level  output  N_BTN  debounced registered level per channel.
REQ-009 o_press  output  N_BTN  one-cycle pulse on accepted 0->1 transition.
REQ-010 o_release  output  N_BTN  one-cycle pulse on accepted 1->0 transition.
REQ-011 o_long  output  N_BTN  one-cycle pulse when press held HOLD_CYCLES.
REQ-012 o_repeat  output  N_BTN  one-cycle pulse every RPT_CYCLES after o_long while held.

Function
REQ-013 Each channel SHALL pass i_btn[k] through a 2-flop synchronizer; sync value s is valid 2 cycles after input change.
REQ-014 Debounce counter SHALL increment each cycle s != o_level, clear to 0 any cycle s == o_level.
REQ-015 When counter == DB_CYCLES-1 and s != o_level, the next edge SHALL toggle o_level, clear counter, and raise o_press or o_release for exactly that one cycle.
REQ-016 Latency: raw input held stable from cycle 0 SHALL produce o_level/o_press change at cycle 2+DB_CYCLES; any bounce back before then SHALL restart the count (no output).
REQ-017 Hold counter SHALL be 0 while o_level==0, increment each cycle o_level==1, width ceil(log2(HOLD_CYCLES+RPT_CYCLES+1)).
REQ-018 o_long SHALL pulse exactly once, in the cycle hold counter reaches HOLD_CYCLES (counted from the o_press cycle = 1).
REQ-019 If RPT_CYCLES>0, o_repeat SHALL pulse each RPT_CYCLES cycles after o_long while o_level==1; repeat sub-counter wraps to 0 on each pulse; hold counter saturates at HOLD_CYCLES.
REQ-020 If RPT_CYCLES==0, o_repeat SHALL stay 0; hold counter saturates at HOLD_CYCLES.
REQ-021 Release before HOLD_CYCLES SHALL produce o_release and no o_long; release after SHALL stop repeats the same cycle o_release asserts.
REQ-022 o_press, o_release, o_long, o_repeat SHALL be mutually exclusive per channel per cycle; o_press never coincides with o_level==0 after the edge.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-024 All outputs SHALL be registered; no combinational path from i_btn to any output.

Reset
REQ-025 i_rst_n low SHALL immediately clear synchronizers, all counters, o_level, o_press, o_release, o_long, o_repeat to 0.
REQ-026 Reset mid-debounce or mid-hold SHALL discard progress; a button held through reset release SHALL produce o_press at 2+DB_CYCLES after reset deassertion.
REQ-027 Reset deassertion SHALL take effect on the next rising i_clk; no pulse SHALL be emitted in the first cycle.

Structure
REQ-028 Shared package SHALL hold default parameter values and a function for counter width (clog2); no typedefs needed beyond that.
REQ-029 One sub-module btn_channel (synchronizer, debounce, hold/repeat for one bit) SHALL be instantiated N_BTN times via generate loop.

Verification (N_BTN=5, DB_CYCLES=4, HOLD_CYCLES=10, RPT_CYCLES=3)
REQ-030 Clean press: i_btn[0] 0->1 at cycle 0, held -> o_press[0] and o_level[0] rise at cycle 6; o_long[0] at cycle 15; o_repeat[0] at cycles 18, 21, 24.
REQ-031 Bounce: i_btn[1] high cycles 0-2, low 3, high from 4 -> no pulse before cycle 10; o_press[1] at cycle 10.
REQ-032 Short press: i_btn[2] high cycles 0-7, low after -> o_press[2] at 6, o_release[2] at 14, no o_long.
REQ-033 Simultaneous: i_btn=5'b11111 at cycle 0 -> o_press=5'b11111 in cycle 6 only.
REQ-034 Reset mid-hold: i_btn[3] held, i_rst_n low at cycle 12 for 2 cycles -> all outputs 0 immediately; o_press[3] 6 cycles after reset release; no o_long before that +9.
REQ-035 RPT_CYCLES=0 build: hold 40 cycles -> one o_long, zero o_repeat.
